// File: rtl/draw_pkg.sv
// Shared types and constants for the VGA draw scheduler.
package draw_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned TILE     = 8;

    localparam logic [3:0] IMG_MAP0   = 4'd0;
    localparam logic [3:0] IMG_MAP7   = 4'd7;
    localparam logic [3:0] IMG_TITLE  = 4'd8;
    localparam logic [3:0] IMG_INSTR  = 4'd9;
    localparam logic [3:0] IMG_SELECT = 4'd10;
    localparam logic [3:0] IMG_CLEAR  = 4'd11;

    localparam logic [1:0] SPR_FLOOR = 2'd0;
    localparam logic [1:0] SPR_CHAR  = 2'd1;
    localparam logic [1:0] SPR_BOX   = 2'd2;
    localparam logic [1:0] SPR_GOAL  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SPR,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Indices past the last real image sweep the screen in colour 0.
    function automatic logic is_blank_img(input logic [3:0] img);
        return img > IMG_CLEAR;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y counter with runtime limits; shared by fills and sprite draws.
module raster_counter #(
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 7
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [XW-1:0] x_max_i,
    input  logic [YW-1:0] y_max_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (x_q == x_max_i) begin
                x_d = '0;
                y_d = (y_q == y_max_i) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == x_max_i) && (y_q == y_max_i);

endmodule

// File: rtl/draw_scheduler.sv
// Framebuffer write-port owner: full-screen fills and 8x8 sprite draws.
// Optional TRANSPARENT_EN: sprite pixels equal to KEY_COLOUR are not plotted.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int unsigned          SCREEN_W   = draw_pkg::SCREEN_W,
    parameter int unsigned          SCREEN_H   = draw_pkg::SCREEN_H,
    parameter int unsigned          TILE       = draw_pkg::TILE,
    parameter int unsigned          COLOUR_W   = 3,
    parameter logic [COLOUR_W-1:0]  KEY_COLOUR = 3'b101
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                fill_req,
    input  logic [3:0]          fill_img,
    input  logic                spr_req,
    input  logic [4:0]          spr_tx,
    input  logic [3:0]          spr_ty,
    input  logic [1:0]          spr_id,
    output logic [3:0]          img_sel,
    output logic [14:0]         img_addr,
    output logic [7:0]          spr_addr,
    output logic                src_spr,
    input  logic [COLOUR_W-1:0] pix_in,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                fill_done,
    output logic                spr_done,
    output logic                busy
);

`ifdef TRANSPARENT_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic        grant_fill, grant_spr, issue;
    logic        is_spr_q, blank_q, oob_q, plot_q;
    logic [3:0]  img_q;
    logic [4:0]  tx_q;
    logic [3:0]  ty_q;
    logic [1:0]  id_q;
    logic [7:0]  vx_q;
    logic [6:0]  vy_q;

    logic [7:0]  cnt_x, x_max, spr_x;
    logic [6:0]  cnt_y, y_max, spr_y;
    logic        cnt_last;

    assign x_max = is_spr_q ? 8'(TILE - 1) : 8'(SCREEN_W - 1);
    assign y_max = is_spr_q ? 7'(TILE - 1) : 7'(SCREEN_H - 1);

    raster_counter #(
        .XW(8),
        .YW(7)
    ) u_raster (
        .clk_i   (clock),
        .rst_ni  (resetn),
        .clr_i   (grant_fill || grant_spr),
        .en_i    (issue),
        .x_max_i (x_max),
        .y_max_i (y_max),
        .x_o     (cnt_x),
        .y_o     (cnt_y),
        .last_o  (cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        grant_fill = 1'b0;
        grant_spr  = 1'b0;
        issue      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fill_req) begin
                    grant_fill = 1'b1;
                    state_d    = ST_FILL;
                end else if (spr_req) begin
                    grant_spr = 1'b1;
                    state_d   = ST_SPR;
                end
            end
            ST_FILL: begin
                issue = 1'b1;
                if (cnt_last) state_d = ST_DRAIN;
            end
            ST_SPR: begin
                // Off-screen tiles spend one cycle here so done timing stays fixed.
                if (oob_q) begin
                    state_d = ST_DONE;
                end else begin
                    issue = 1'b1;
                    if (cnt_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign spr_x = 8'(32'(tx_q) * TILE + 32'(cnt_x));
    assign spr_y = 7'(32'(ty_q) * TILE + 32'(cnt_y));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            is_spr_q <= 1'b0;
            blank_q  <= 1'b0;
            oob_q    <= 1'b0;
            plot_q   <= 1'b0;
            img_q    <= '0;
            tx_q     <= '0;
            ty_q     <= '0;
            id_q     <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
        end else begin
            state_q <= state_d;
            plot_q  <= issue;
            if (grant_fill) begin
                is_spr_q <= 1'b0;
                img_q    <= fill_img;
                blank_q  <= is_blank_img(fill_img);
            end
            if (grant_spr) begin
                is_spr_q <= 1'b1;
                blank_q  <= 1'b0;
                tx_q     <= spr_tx;
                ty_q     <= spr_ty;
                id_q     <= spr_id;
                oob_q    <= (32'(spr_tx) >= SCREEN_W / TILE) || (32'(spr_ty) >= SCREEN_H / TILE);
            end
            // Coordinates travel one cycle behind the address, matching ROM latency.
            if (issue) begin
                vx_q <= is_spr_q ? spr_x : cnt_x;
                vy_q <= is_spr_q ? spr_y : cnt_y;
            end
        end
    end

    assign img_sel    = img_q;
    assign img_addr   = 15'(32'(cnt_y) * SCREEN_W + 32'(cnt_x));
    assign spr_addr   = 8'(32'(id_q) * TILE * TILE + 32'(cnt_y) * TILE + 32'(cnt_x));
    assign src_spr    = is_spr_q;
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = (plot_q && !blank_q) ? pix_in : '0;
    assign vga_plot   = plot_q && !(TRANSP_EN && is_spr_q && (pix_in == KEY_COLOUR));
    assign fill_done  = (state_q == ST_DONE) && !is_spr_q;
    assign spr_done   = (state_q == ST_DONE) && is_spr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: vector table, hand-written corner sequences.
module tb_draw_scheduler;

    localparam logic [2:0] KEY = 3'b101;
`ifdef TRANSPARENT_EN
    localparam int KEY_DROP = 10;
`else
    localparam int KEY_DROP = 0;
`endif

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        fill_req = 1'b0;
    logic [3:0]  fill_img = '0;
    logic        spr_req = 1'b0;
    logic [4:0]  spr_tx = '0;
    logic [3:0]  spr_ty = '0;
    logic [1:0]  spr_id = '0;
    logic [3:0]  img_sel;
    logic [14:0] img_addr;
    logic [7:0]  spr_addr;
    logic        src_spr;
    logic [2:0]  pix_in = '0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        fill_done;
    logic        spr_done;
    logic        busy;

    always #5 clock = ~clock;

    draw_scheduler dut (
        .clock(clock), .resetn(resetn),
        .fill_req(fill_req), .fill_img(fill_img),
        .spr_req(spr_req), .spr_tx(spr_tx), .spr_ty(spr_ty), .spr_id(spr_id),
        .img_sel(img_sel), .img_addr(img_addr), .spr_addr(spr_addr), .src_spr(src_spr),
        .pix_in(pix_in),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .fill_done(fill_done), .spr_done(spr_done), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int seed_i, seed_s;
    bit key_mask [256];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [2:0] img_rom(int sel, int addr);
        return 3'((addr ^ (addr >> 3) ^ (addr >> 7) ^ (sel * 5) ^ seed_i) & 7);
    endfunction

    function automatic logic [2:0] spr_rom(int addr);
        logic [2:0] h;
        if (key_mask[addr]) return KEY;
        h = 3'(((addr * 3) ^ (addr >> 2) ^ seed_s) & 7);
        if (h == KEY) h = 3'b010;
        return h;
    endfunction

    // ROM models with one cycle read latency; address log keyed by cycle.
    logic [14:0] ilog [int];
    logic [7:0]  slog [int];
    always @(posedge clock) begin
        pix_in <= src_spr ? spr_rom(int'(spr_addr)) : img_rom(int'(img_sel), int'(img_addr));
        ilog[cyc] = img_addr;
        slog[cyc] = spr_addr;
    end

    typedef struct { int cyc; int x; int y; int col; } plot_t;
    typedef struct { int cyc; bit spr; int addr; } iss_t;
    plot_t plots[$];
    plot_t exp_plots[$];
    iss_t  exp_iss[$];
    int    fd_cyc[$];
    int    sd_cyc[$];

    always @(negedge clock) begin
        if (resetn) begin
            if (vga_plot) plots.push_back('{cyc, int'(vga_x), int'(vga_y), int'(vga_colour)});
            if (fill_done) fd_cyc.push_back(cyc);
            if (spr_done) sd_cyc.push_back(cyc);
        end
    end

    function automatic void check(string nm, bit ok, string detail);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", nm, detail);
        end
    endfunction

    // Expected issue/plot stream for one granted request whose grant cycle is base.
    function automatic void model_txn(bit f, int img, int tx, int ty, int id, int base);
        if (f) begin
            for (int i = 0; i < 19200; i++) begin
                int x = i % 160;
                int y = i / 160;
                exp_iss.push_back('{base + 1 + i, 1'b0, y * 160 + x});
                exp_plots.push_back('{base + 2 + i, x, y, (img >= 12) ? 0 : int'(img_rom(img, y * 160 + x))});
            end
        end else if (tx < 20 && ty < 15) begin
            for (int i = 0; i < 64; i++) begin
                int a = id * 64 + (i / 8) * 8 + (i % 8);
                int c = int'(spr_rom(a));
                bit keep = 1'b1;
`ifdef TRANSPARENT_EN
                keep = (c != int'(KEY));
`endif
                exp_iss.push_back('{base + 1 + i, 1'b1, a});
                if (keep) exp_plots.push_back('{base + 2 + i, tx * 8 + i % 8, ty * 8 + i / 8, c});
            end
        end
    endfunction

    task automatic run_txn(string nm, bit do_f, bit do_s, logic [3:0] img, logic [4:0] tx,
                           logic [3:0] ty, logic [1:0] id, int exp_np, int exp_fd, int exp_sd);
        int t0, k, bad;
        bit fd_seen, sd_seen;
        @(negedge clock);
        check({nm, ":idle_before"}, busy == 1'b0, $sformatf("busy=%0b required 0", busy));
        plots.delete(); fd_cyc.delete(); sd_cyc.delete();
        ilog.delete(); slog.delete(); exp_plots.delete(); exp_iss.delete();
        fill_img = img; spr_tx = tx; spr_ty = ty; spr_id = id;
        fill_req = do_f; spr_req = do_s;
        t0 = cyc;
        if (do_f) model_txn(1'b1, int'(img), 0, 0, 0, t0);
        if (do_s) model_txn(1'b0, 0, int'(tx), int'(ty), int'(id), do_f ? t0 + 19203 : t0);
        fd_seen = !do_f; sd_seen = !do_s; k = 0;
        while (!(fd_seen && sd_seen) && k < 25000) begin
            @(negedge clock);
            k++;
            if (k == 1) begin
                if (do_f) fill_img = 4'($urandom);
                else begin
                    spr_tx = 5'($urandom); spr_ty = 4'($urandom); spr_id = 2'($urandom);
                end
            end
            if (fill_done) begin fill_req = 1'b0; fd_seen = 1'b1; end
            if (spr_done)  begin spr_req = 1'b0;  sd_seen = 1'b1; end
        end
        check({nm, ":completes"}, fd_seen && sd_seen, $sformatf("fill_done seen=%0b spr_done seen=%0b required 1/1 within %0d cycles", fd_seen, sd_seen, k));
        fill_req = 1'b0; spr_req = 1'b0;
        repeat (3) @(negedge clock);

        check({nm, ":plot_count"}, plots.size() == exp_np, $sformatf("plots=%0d required %0d", plots.size(), exp_np));
        bad = -1;
        for (int i = 0; i < exp_plots.size() && i < plots.size(); i++) begin
            if (bad < 0 && (plots[i].cyc != exp_plots[i].cyc || plots[i].x != exp_plots[i].x ||
                            plots[i].y != exp_plots[i].y || plots[i].col != exp_plots[i].col)) bad = i;
        end
        if (bad < 0 && plots.size() != exp_plots.size()) bad = (plots.size() < exp_plots.size()) ? plots.size() : exp_plots.size();
        if (bad >= 0 && bad < plots.size() && bad < exp_plots.size())
            check({nm, ":plot_seq"}, 1'b0, $sformatf("#%0d got c%0d (%0d,%0d) col%0d required c%0d (%0d,%0d) col%0d", bad,
                  plots[bad].cyc - t0, plots[bad].x, plots[bad].y, plots[bad].col,
                  exp_plots[bad].cyc - t0, exp_plots[bad].x, exp_plots[bad].y, exp_plots[bad].col));
        else
            check({nm, ":plot_seq"}, bad < 0, $sformatf("length got %0d required %0d", plots.size(), exp_plots.size()));

        bad = -1;
        foreach (exp_iss[i]) begin
            int got;
            got = -1;
            if (exp_iss[i].spr && slog.exists(exp_iss[i].cyc)) got = int'(slog[exp_iss[i].cyc]);
            if (!exp_iss[i].spr && ilog.exists(exp_iss[i].cyc)) got = int'(ilog[exp_iss[i].cyc]);
            if (bad < 0 && got != exp_iss[i].addr) begin
                bad = i;
                check({nm, ":addr_seq"}, 1'b0, $sformatf("issue #%0d addr=%0d required %0d", i, got, exp_iss[i].addr));
            end
        end
        if (bad < 0 && exp_iss.size() > 0) check({nm, ":addr_seq"}, 1'b1, "");

        if (exp_fd >= 0)
            check({nm, ":fill_done"}, fd_cyc.size() == 1 && fd_cyc[0] - t0 == exp_fd,
                  $sformatf("pulses=%0d first at %0d required 1 at %0d", fd_cyc.size(), fd_cyc.size() ? fd_cyc[0] - t0 : -1, exp_fd));
        else
            check({nm, ":no_fill_done"}, fd_cyc.size() == 0, $sformatf("pulses=%0d required 0", fd_cyc.size()));
        if (exp_sd >= 0)
            check({nm, ":spr_done"}, sd_cyc.size() == 1 && sd_cyc[0] - t0 == exp_sd,
                  $sformatf("pulses=%0d first at %0d required 1 at %0d", sd_cyc.size(), sd_cyc.size() ? sd_cyc[0] - t0 : -1, exp_sd));
        else
            check({nm, ":no_spr_done"}, sd_cyc.size() == 0, $sformatf("pulses=%0d required 0", sd_cyc.size()));
        if (do_f)
            check({nm, ":img_sel"}, img_sel == img, $sformatf("img_sel=%0d required %0d", img_sel, img));
        check({nm, ":src_spr"}, src_spr == do_s, $sformatf("src_spr=%0b required %0b", src_spr, do_s));
        check({nm, ":idle_after"}, busy == 1'b0, $sformatf("busy=%0b required 0", busy));
    endtask

    typedef struct {
        string nm; bit f; logic [3:0] img; logic [4:0] tx; logic [3:0] ty; logic [1:0] id;
        int np; int fd; int sd;
    } vec_t;
    vec_t vecs[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n;
        seed_i = int'($urandom_range(0, 7));
        seed_s = int'($urandom_range(0, 7));

        vecs.push_back('{"fill_title",   1'b1, 4'd8,  5'd0,  4'd0,  2'd0, 19200, 19202, -1});
        vecs.push_back('{"spr_box",      1'b0, 4'd0,  5'd3,  4'd2,  2'd2, 64,    -1,    66});
        vecs.push_back('{"spr_tx20",     1'b0, 4'd0,  5'd20, 4'd0,  2'd1, 0,     -1,    2});
        vecs.push_back('{"spr_ty15",     1'b0, 4'd0,  5'd0,  4'd15, 2'd3, 0,     -1,    2});
        vecs.push_back('{"spr_corner",   1'b0, 4'd0,  5'd19, 4'd14, 2'd3, 64,    -1,    66});
        vecs.push_back('{"spr_origin",   1'b0, 4'd0,  5'd0,  4'd0,  2'd0, 64,    -1,    66});
        vecs.push_back('{"fill_blank13", 1'b1, 4'd13, 5'd0,  4'd0,  2'd0, 19200, 19202, -1});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{$sformatf("spr_rand%0d", i), 1'b0, 4'd0, 5'($urandom_range(0, 19)),
                             4'($urandom_range(0, 14)), 2'($urandom), 64, -1, 66});

        repeat (3) @(negedge clock);
        check("reset_state", {vga_plot, vga_x, vga_y, vga_colour, fill_done, spr_done, busy,
                              img_sel, img_addr, spr_addr, src_spr} == '0,
              $sformatf("plot=%0b x=%0d y=%0d busy=%0b img_addr=%0d required all 0", vga_plot, vga_x, vga_y, busy, img_addr));
        resetn = 1'b1;

        foreach (vecs[i])
            run_txn(vecs[i].nm, vecs[i].f, 1'b0 | !vecs[i].f, vecs[i].img, vecs[i].tx, vecs[i].ty,
                    vecs[i].id, vecs[i].np, vecs[i].fd, vecs[i].sd);

        n = 0;
        while (n < 10) begin
            k = int'($urandom_range(64, 127));
            if (!key_mask[k]) begin key_mask[k] = 1'b1; n++; end
        end
        run_txn("spr_key", 1'b0, 1'b1, 4'd0, 5'd5, 4'd7, 2'd1, 64 - KEY_DROP, -1, 66);
        foreach (key_mask[i]) key_mask[i] = 1'b0;

        @(negedge clock);
        plots.delete();
        fill_img = 4'd4; fill_req = 1'b1; k = 0;
        while (plots.size() < 5000 && k < 6000) begin
            @(negedge clock);
            k++;
        end
        check("reset_mid:reached", plots.size() >= 5000, $sformatf("plots=%0d required 5000", plots.size()));
        resetn = 1'b0;
        #1;
        check("reset_mid:outputs", {vga_plot, vga_x, vga_y, vga_colour, fill_done, spr_done, busy,
                                    img_sel, img_addr, spr_addr, src_spr} == '0,
              $sformatf("plot=%0b x=%0d y=%0d busy=%0b img_sel=%0d img_addr=%0d required all 0", vga_plot, vga_x, vga_y, busy, img_sel, img_addr));
        fill_req = 1'b0;
        @(negedge clock);
        resetn = 1'b1;

        run_txn("fill_then_spr", 1'b1, 1'b1, 4'd6, 5'($urandom_range(0, 19)), 4'($urandom_range(0, 14)),
                2'($urandom), 19264, 19202, 19269);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Owns the single VGA framebuffer write port.
- Arbitrates between full-screen image fills (map loads, title, instructions, select, clear screens) and 8x8 tile sprite draws (box, char, floor/clear).
- Generates ROM read addresses, waits out ROM latency, and drives plot/x/y/colour to the VGA adapter.
- Returns a done pulse per request, so the game FSM no longer counts pixels itself.

Parameters:
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- TILE, 8, sprite edge in pixels
- COLOUR_W, 3, colour bits per pixel
- KEY_COLOUR, 3'b101, transparent colour (used only with the optional feature)

Ports:
- clock  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- fill_req  in  1  full-screen fill request, level; held until fill_done
- fill_img  in  4  image index 0..11 (0-7 maps, 8 title, 9 instructions, 10 select, 11 clear)
- spr_req  in  1  sprite request, level; held until spr_done
- spr_tx  in  5  tile column 0..19
- spr_ty  in  4  tile row 0..14
- spr_id  in  2  sprite 0 floor, 1 char, 2 box, 3 goal
- img_sel  out  4  latched image index for the image ROM mux
- img_addr  out  15  image ROM address, y*160+x
- spr_addr  out  8  sprite ROM address, id*64+row*8+col
- src_spr  out  1  1 = pix_in comes from sprite ROM, 0 = image ROM
- pix_in  in  COLOUR_W  ROM data, valid 1 cycle after address
- vga_x  out  8  plot x
- vga_y  out  7  plot y
- vga_colour  out  COLOUR_W  plot colour
- vga_plot  out  1  write enable
- fill_done  out  1  1-cycle pulse
- spr_done  out  1  1-cycle pulse
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async): state IDLE; all outputs 0; counters 0.
- States: IDLE, FILL, SPR, DRAIN, DONE.
- IDLE: fill_req has priority over spr_req. On grant, latch the request arguments, clear the x/y counters, and go to FILL or SPR.
- FILL: each cycle issue img_addr for (x,y); x wraps 159->0 and increments y. After issuing (159,119), go to DRAIN.
- SPR: each cycle issue spr_addr for (col,row), 0..7 each. After (7,7), go to DRAIN.
- Pipeline:
  - x/y are delayed by 1 cycle alongside the ROM read.
  - vga_plot is high exactly 1 cycle after each issued address, with vga_x/vga_y = delayed coords.
  - For sprites, coords are tx*8+col and ty*8+row.
  - vga_colour = pix_in.
- DRAIN: 1 cycle for the last plot, then DONE.
- DONE: pulse the matching done output for 1 cycle, then IDLE.
- Latency: grant sampled at cycle 0 -> first plot at cycle 2.
  - Fill: last plot at 19201, fill_done at 19202, 19200 plots total.
  - Sprite: last plot at 65, spr_done at 66, 64 plots total.
- Requesters drop req in the cycle they see done. IDLE is held at least 1 cycle before the next grant.
- Dropping req mid-operation is ignored; the operation completes and done still pulses.
- Argument changes after grant are ignored; arguments are latched at grant.
- fill_img 12..15: full 19200-pixel sweep plotting colour 0; pix_in is ignored.
- spr_tx>=20 or spr_ty>=15: no plots; go straight to DONE; spr_done pulses at cycle 2.
- No preemption: a fill request arriving during SPR waits for IDLE.
- Simultaneous fill_req and spr_req in IDLE: fill is granted first; the sprite is granted after fill_done.

Optional Feature:
- Macro TRANSPARENT_EN.
- Defined: during SPR draws, a pixel with pix_in == KEY_COLOUR suppresses vga_plot for that cycle. Timing and done latency are unchanged. Fills are unaffected.
- Undefined: every sprite pixel is plotted.

Decomposition:
- Package draw_pkg holds:
  - state encoding enum
  - SCREEN_W/SCREEN_H/TILE constants
  - image index constants (IMG_MAP0..IMG_CLEAR)
  - sprite id constants (SPR_FLOOR, SPR_CHAR, SPR_BOX, SPR_GOAL)
- One sub-module, raster_counter: x/y counter with runtime width/height limits, clear, enable, and a "last" flag. A single instance is reused for fills (160x120) and sprites (8x8).

Test Plan:
- fill_req=1, fill_img=8 from reset -> img_sel=8; first plot (0,0) at cycle 2; 19200 plots; last (159,119) at cycle 19201; fill_done at 19202 only.
- spr_req, tx=3, ty=2, id=2 -> spr_addr 128..191 in order; plots cover x 24..31, y 16..23; spr_done at cycle 66.
- fill_req and spr_req rise in the same cycle -> fill completes first; sprite's first plot occurs 2 cycles after fill's IDLE return; each done pulses once.
- spr_tx=20 -> zero vga_plot cycles; spr_done at cycle 2.
- resetn low mid-fill at pixel 5000 -> all outputs 0 immediately, state IDLE; a new fill after release restarts at (0,0).
- TRANSPARENT_EN with pix_in=3'b101 on 10 sprite pixels -> exactly 54 plots; spr_done still at cycle 66.
